// File: rtl/stack_pointer_pkg.sv
// Shared constants and operation encoding for the Hack VM stack pointer.
// SP_BASE and SP_LIMIT are also the parameter defaults for the VM sequencer.
`ifndef STACK_POINTER_PKG_SV
`define STACK_POINTER_PKG_SV
package stack_pointer_pkg;

  localparam logic [15:0] SP_BASE  = 16'd256;
  localparam logic [15:0] SP_LIMIT = 16'd2047;

  // Resolved per-cycle operation after applying reset > load > push/pop priority
  typedef enum logic [2:0] {
    SP_OP_IDLE    = 3'd0,
    SP_OP_RESET   = 3'd1,
    SP_OP_LOAD    = 3'd2,
    SP_OP_PUSH    = 3'd3,
    SP_OP_POP     = 3'd4,
    SP_OP_REPLACE = 3'd5
  } sp_op_e;

  function automatic sp_op_e sp_decode(input logic reset, input logic load,
                                       input logic push, input logic pop);
    sp_op_e op;
    op = SP_OP_IDLE;
    if (reset)             op = SP_OP_RESET;
    else if (load)         op = SP_OP_LOAD;
    else if (push && pop)  op = SP_OP_REPLACE;
    else if (push)         op = SP_OP_PUSH;
    else if (pop)          op = SP_OP_POP;
    return op;
  endfunction

endpackage
`endif

// File: rtl/stack_pointer_dec16.sv
// 16-bit combinational decrementer: half-subtractor chain with borrow-in 1 at bit 0.
module dec16 (
  input  logic [15:0] i_a,
  output logic [15:0] o_diff
);
  logic [15:0] w_borrow;

  assign w_borrow[0] = 1'b1;

  for (genvar i = 0; i < 16; i++) begin : g_hs
    assign o_diff[i] = i_a[i] ^ w_borrow[i];
    if (i < 15) begin : g_borrow
      // Borrow propagates while the minuend bit is 0
      assign w_borrow[i+1] = ~i_a[i] & w_borrow[i];
    end
  end
endmodule

// File: rtl/stack_pointer_inc16.sv
// 16-bit combinational incrementer: half-adder chain with carry-in 1 at bit 0.
module inc16 (
  input  logic [15:0] i_a,
  output logic [15:0] o_sum
);
  logic [15:0] w_carry;

  assign w_carry[0] = 1'b1;

  for (genvar i = 0; i < 16; i++) begin : g_ha
    assign o_sum[i] = i_a[i] ^ w_carry[i];
    if (i < 15) begin : g_carry
      assign w_carry[i+1] = i_a[i] & w_carry[i];
    end
  end
endmodule

// File: rtl/stack_pointer.sv
// Hack VM stack pointer: counts up on push, down on pop, with full/empty
// status and sticky overflow/underflow flags for rejected operations.
module stack_pointer
  import stack_pointer_pkg::*;
#(
  parameter logic [15:0] BASE  = SP_BASE,
  parameter logic [15:0] LIMIT = SP_LIMIT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [15:0] in,
  input  logic        push,
  input  logic        pop,
  output logic [15:0] out,
  output logic [15:0] top,
  output logic        empty,
  output logic        full,
  output logic        overflow,
  output logic        underflow
);

  logic [15:0] r_sp;
  logic        r_overflow;
  logic        r_underflow;

  logic [15:0] w_sp_inc;
  logic [15:0] w_sp_dec;
  logic        w_full;
  logic        w_empty;
  sp_op_e      w_op;

  inc16 u_inc (.i_a(r_sp), .o_sum(w_sp_inc));
  dec16 u_dec (.i_a(r_sp), .o_diff(w_sp_dec));

  // Magnitude compares keep an out-of-range loaded SP from wrapping.
  assign w_full  = (r_sp > LIMIT);
  assign w_empty = (r_sp <= BASE);
  assign w_op    = sp_decode(reset, load, push, pop);

  always_ff @(posedge clk) begin
    case (w_op)
      SP_OP_RESET: begin
        r_sp        <= BASE;
        r_overflow  <= 1'b0;
        r_underflow <= 1'b0;
      end
      SP_OP_LOAD: begin
        r_sp        <= in;
        r_overflow  <= 1'b0;
        r_underflow <= 1'b0;
      end
      SP_OP_PUSH: begin
        if (w_full) r_overflow <= 1'b1;
        else        r_sp       <= w_sp_inc;
      end
      SP_OP_POP: begin
        if (w_empty) r_underflow <= 1'b1;
        else         r_sp        <= w_sp_dec;
      end
      default: begin
        // Idle and replace-top leave SP and both flags untouched
        r_sp        <= r_sp;
        r_overflow  <= r_overflow;
        r_underflow <= r_underflow;
      end
    endcase
  end

  assign out       = r_sp;
  assign top       = w_sp_dec;
  assign empty     = w_empty;
  assign full      = w_full;
  assign overflow  = r_overflow;
  assign underflow = r_underflow;

endmodule

// File: tb/tb_stack_pointer.sv
// Directed bench for stack_pointer: linear step sequence with hand-computed
// expectations checked by immediate assertions.
module tb_stack_pointer;

  logic        clk;
  logic        reset;
  logic        load;
  logic [15:0] in;
  logic        push;
  logic        pop;
  logic [15:0] out;
  logic [15:0] top;
  logic        empty;
  logic        full;
  logic        overflow;
  logic        underflow;

  int checks = 0;
  int errors = 0;

  stack_pointer dut (
    .clk       (clk),
    .reset     (reset),
    .load      (load),
    .in        (in),
    .push      (push),
    .pop       (pop),
    .out       (out),
    .top       (top),
    .empty     (empty),
    .full      (full),
    .overflow  (overflow),
    .underflow (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply inputs for one rising edge, then settle 1ns past the edge.
  task automatic step(input logic r, input logic l, input logic [15:0] v,
                      input logic pu, input logic po);
    reset = r;
    load  = l;
    in    = v;
    push  = pu;
    pop   = po;
    @(posedge clk);
    #1;
    reset = 1'b0;
    load  = 1'b0;
    push  = 1'b0;
    pop   = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Status packed as {empty, full, overflow, underflow}
  task automatic chk_all(input string tag, input logic [15:0] e_out,
                         input logic [15:0] e_top, input logic [3:0] e_st);
    chk({tag, "_out"}, out, e_out);
    chk({tag, "_top"}, top, e_top);
    chk({tag, "_st"}, {12'd0, empty, full, overflow, underflow}, {12'd0, e_st});
  endtask

  initial begin
    reset = 1'b1; load = 1'b0; in = 16'd0; push = 1'b0; pop = 1'b0;
    @(negedge clk);
    step(1, 0, 0, 0, 0);
    chk_all("reset", 16'd256, 16'd255, 4'b1000);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0);
    chk_all("idle3", 16'd256, 16'd255, 4'b1000);

    step(0, 0, 0, 1, 0); chk_all("push1", 16'd257, 16'd256, 4'b0000);
    step(0, 0, 0, 1, 0); chk_all("push2", 16'd258, 16'd257, 4'b0000);
    step(0, 0, 0, 1, 0); chk_all("push3", 16'd259, 16'd258, 4'b0000);
    step(0, 0, 0, 0, 1); chk_all("pop1", 16'd258, 16'd257, 4'b0000);

    step(0, 1, 16'd2047, 0, 0); chk_all("ld2047", 16'd2047, 16'd2046, 4'b0000);
    step(0, 0, 0, 1, 0); chk_all("push_full", 16'd2048, 16'd2047, 4'b0100);
    step(0, 0, 0, 1, 0); chk_all("push_ovf", 16'd2048, 16'd2047, 4'b0110);
    step(0, 0, 0, 1, 1); chk_all("repl_full", 16'd2048, 16'd2047, 4'b0110);
    step(0, 0, 0, 0, 1); chk_all("pop_keep_ovf", 16'd2047, 16'd2046, 4'b0010);

    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1); chk_all("pop_unf", 16'd256, 16'd255, 4'b1001);
    step(0, 0, 0, 1, 0); chk_all("push_keep_unf", 16'd257, 16'd256, 4'b0001);
    step(0, 1, 16'd300, 0, 0); chk_all("ld300", 16'd300, 16'd299, 4'b0000);

    step(0, 1, 16'd500, 0, 0);
    step(0, 0, 0, 1, 1); chk_all("repl1", 16'd500, 16'd499, 4'b0000);
    step(0, 0, 0, 1, 1); chk_all("repl2", 16'd500, 16'd499, 4'b0000);
    step(0, 1, 16'd256, 0, 0);
    step(0, 0, 0, 1, 1); chk_all("repl_empty", 16'd256, 16'd255, 4'b1000);

    step(0, 1, 16'd1000, 1, 0); chk_all("ld_over_push", 16'd1000, 16'd999, 4'b0000);
    step(0, 1, 16'd1000, 0, 1); chk_all("ld_over_pop", 16'd1000, 16'd999, 4'b0000);

    step(0, 1, 16'hFFFF, 0, 0); chk_all("ldFFFF", 16'hFFFF, 16'hFFFE, 4'b0100);
    step(0, 0, 0, 1, 0); chk_all("push_FFFF", 16'hFFFF, 16'hFFFE, 4'b0110);
    step(0, 1, 16'd0, 0, 0); chk_all("ld0", 16'd0, 16'hFFFF, 4'b1000);
    step(0, 0, 0, 0, 1); chk_all("pop_0", 16'd0, 16'hFFFF, 4'b1001);
    step(0, 0, 0, 0, 0); chk_all("idle_hold", 16'd0, 16'hFFFF, 4'b1001);

    step(0, 1, 16'd2048, 0, 0);
    step(0, 0, 0, 1, 0); chk_all("pre_rst_ovf", 16'd2048, 16'd2047, 4'b0110);
    step(1, 0, 0, 1, 0); chk_all("rst_push", 16'd256, 16'd255, 4'b1000);
    step(0, 1, 16'd700, 0, 0);
    step(1, 1, 16'd900, 0, 1); chk_all("rst_load", 16'd256, 16'd255, 4'b1000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
